// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - width helpers and FSM encoding shared by histogram_mc and its bin RAM
package hist_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } hist_state_t;

    // Number of bits needed to hold the value itself (0 needs 0 bits).
    function automatic int clogb2(input longint value);
        int bits = 0;
        for (int i = 0; i < 63; i++) begin
            if ((value >> i) != 0) bits = i + 1;
        end
        return bits;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (clogb2(num_ch - 1) > 1) ? clogb2(num_ch - 1) : 1;
    endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// rtl/hist_bin_ram.sv - one channel's bin store: port A read+write (read-old), port B read-only
module hist_bin_ram #(
    parameter int DATA_WIDTH    = 19,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     a_we,
    input  logic [ADDRESS_WIDTH-1:0] a_waddr,
    input  logic [DATA_WIDTH-1:0]    a_wdata,
    input  logic [ADDRESS_WIDTH-1:0] a_raddr,
    output logic [DATA_WIDTH-1:0]    a_q,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0]    b_q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    always_ff @(posedge clk) begin
        if (a_we) mem[a_waddr] <= a_wdata;
        a_q <= mem[a_raddr];
        b_q <= mem[b_addr];
    end

endmodule

// File: rtl/histogram_mc.sv
// rtl/histogram_mc.sv - multi-channel histogram accumulator; HISTOGRAM_SAT_EN selects saturating counts
module histogram_mc
    import hist_pkg::*;
#(
    parameter int  PIXEL_WIDTH   = 8,
    parameter int  NUM_CH        = 3,
    parameter int  IMAGE_WIDTH   = 640,
    parameter int  IMAGE_HEIGHT  = 480,
    parameter int  COLOR_RANGE   = 256,
    localparam int DATA_WIDTH    = clogb2(IMAGE_WIDTH * IMAGE_HEIGHT),
    localparam int ADDRESS_WIDTH = clogb2(COLOR_RANGE - 1),
    localparam int CH_WIDTH      = ch_width(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [NUM_CH*PIXEL_WIDTH-1:0] pixel_in,
    input  logic                          pixel_valid,
    input  logic                          clear,
    output logic                          busy,
    input  logic                          rd_req,
    input  logic [CH_WIDTH-1:0]           rd_ch,
    input  logic [ADDRESS_WIDTH-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [NUM_CH-1:0]             ovf
);

    hist_state_t              state;
    logic [ADDRESS_WIDTH-1:0] sweep_addr;
    logic                     s1_valid;
    logic                     last_wr_valid;
    logic                     inc_we;
    logic                     ram_we;
    logic                     rd_valid_q;
    logic [CH_WIDTH-1:0]      rd_ch_q;

    logic [ADDRESS_WIDTH-1:0] s0_bin       [NUM_CH];
    logic [ADDRESS_WIDTH-1:0] s1_bin       [NUM_CH];
    logic [ADDRESS_WIDTH-1:0] last_wr_addr [NUM_CH];
    logic [DATA_WIDTH-1:0]    last_wr_data [NUM_CH];
    logic [DATA_WIDTH-1:0]    ram_q        [NUM_CH];
    logic [DATA_WIDTH-1:0]    b_q          [NUM_CH];
    logic [DATA_WIDTH-1:0]    old_cnt      [NUM_CH];
    logic [DATA_WIDTH-1:0]    new_cnt      [NUM_CH];
    logic [ADDRESS_WIDTH-1:0] ram_waddr    [NUM_CH];
    logic [DATA_WIDTH-1:0]    ram_wdata    [NUM_CH];

    // Only the top ADDRESS_WIDTH bits of each component select a bin.
    logic unused_pixel_lsbs;
    assign unused_pixel_lsbs = ^pixel_in;

`ifdef HISTOGRAM_SAT_EN
    localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
    logic [NUM_CH-1:0] sat_hit;
`endif

    // A stage-1 write is dropped when clear is sampled in the same cycle.
    always_comb begin
        inc_we = s1_valid && !clear;
        ram_we = (state == SWEEP) || inc_we;
`ifdef HISTOGRAM_SAT_EN
        sat_hit = '0;
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            s0_bin[ch]  = pixel_in[ch*PIXEL_WIDTH + PIXEL_WIDTH - ADDRESS_WIDTH +: ADDRESS_WIDTH];
            old_cnt[ch] = (last_wr_valid && (last_wr_addr[ch] == s1_bin[ch])) ? last_wr_data[ch]
                                                                              : ram_q[ch];
`ifdef HISTOGRAM_SAT_EN
            sat_hit[ch] = (old_cnt[ch] == CNT_MAX);
            new_cnt[ch] = sat_hit[ch] ? old_cnt[ch] : old_cnt[ch] + 1'b1;
`else
            new_cnt[ch] = old_cnt[ch] + 1'b1;
`endif
            ram_waddr[ch] = (state == SWEEP) ? sweep_addr : s1_bin[ch];
            ram_wdata[ch] = (state == SWEEP) ? '0 : new_cnt[ch];
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state         <= SWEEP;
            busy          <= 1'b1;
            sweep_addr    <= '0;
            s1_valid      <= 1'b0;
            last_wr_valid <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_ch_q       <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                s1_bin[ch]       <= '0;
                last_wr_addr[ch] <= '0;
                last_wr_data[ch] <= '0;
            end
        end else begin
            s1_valid      <= pixel_valid && (state == RUN) && !clear;
            last_wr_valid <= inc_we;
            rd_valid_q    <= rd_req && (state == RUN);
            rd_ch_q       <= rd_ch;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                s1_bin[ch] <= s0_bin[ch];
                if (inc_we) begin
                    last_wr_addr[ch] <= s1_bin[ch];
                    last_wr_data[ch] <= new_cnt[ch];
                end
            end
            if (state == SWEEP) begin
                if (clear) begin
                    sweep_addr <= '0;
                end else if (sweep_addr == ADDRESS_WIDTH'(COLOR_RANGE - 1)) begin
                    state      <= RUN;
                    busy       <= 1'b0;
                    sweep_addr <= '0;
                end else begin
                    sweep_addr <= sweep_addr + 1'b1;
                end
            end else if (clear) begin
                state      <= SWEEP;
                busy       <= 1'b1;
                sweep_addr <= '0;
            end
        end
    end

`ifdef HISTOGRAM_SAT_EN
    logic [NUM_CH-1:0] ovf_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ovf_q <= '0;
        end else if ((state == RUN) && clear) begin
            ovf_q <= '0;
        end else if (inc_we) begin
            ovf_q <= ovf_q | sat_hit;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = '0;
`endif

    // Out-of-range channels read back as zero but still acknowledge.
    always_comb begin
        rd_data = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rd_valid_q && (rd_ch_q == CH_WIDTH'(ch))) rd_data = b_q[ch];
        end
    end

    assign rd_valid = rd_valid_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        hist_bin_ram #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
        ) u_ram (
            .clk     (clk),
            .a_we    (ram_we),
            .a_waddr (ram_waddr[ch]),
            .a_wdata (ram_wdata[ch]),
            .a_raddr (s0_bin[ch]),
            .a_q     (ram_q[ch]),
            .b_addr  (rd_addr),
            .b_q     (b_q[ch])
        );
    end

endmodule

// File: tb/tb_histogram_mc.sv
// tb/tb_histogram_mc.sv - self-checking bench for histogram_mc against a cycle-level behavioural model
module tb_histogram_mc;

    localparam int PW   = 8;
    localparam int NCH  = 3;
    localparam int CR   = 64;
    localparam int DW   = 5;
    localparam int AW   = 6;
    localparam int CW   = 2;
    localparam int MAXV = 31;

    logic              clk = 1'b0;
    logic              arstn;
    logic [NCH*PW-1:0] pixel_in;
    logic              pixel_valid;
    logic              clear;
    logic              busy;
    logic              rd_req;
    logic [CW-1:0]     rd_ch;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic [NCH-1:0]    ovf;

    int n_checks = 0;
    int n_errors = 0;

    histogram_mc #(
        .PIXEL_WIDTH  (PW),
        .NUM_CH       (NCH),
        .IMAGE_WIDTH  (4),
        .IMAGE_HEIGHT (4),
        .COLOR_RANGE  (CR)
    ) dut (
        .clk         (clk),
        .arstn       (arstn),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .clear       (clear),
        .busy        (busy),
        .rd_req      (rd_req),
        .rd_ch       (rd_ch),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Behavioural model: bins as plain counters, one-cycle commit delay, sweep as a countdown.
    int           m_bins [NCH][CR];
    bit [NCH-1:0] m_ovf;
    bit           m_busy;
    int           m_left;
    bit           m_pend;
    int           m_pend_bin [NCH];
    bit           e_rd_valid;
    int           e_rd_data;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_busy     = 1'b1;
            m_left     = CR;
            m_pend     = 1'b0;
            m_ovf      = '0;
            e_rd_valid = 1'b0;
            e_rd_data  = 0;
        end else begin
            e_rd_valid = rd_req && !m_busy;
            e_rd_data  = 0;
            if (e_rd_valid && (int'(rd_ch) < NCH)) e_rd_data = m_bins[rd_ch][rd_addr];
            if (m_pend && !clear) begin
                for (int ch = 0; ch < NCH; ch++) begin
`ifdef HISTOGRAM_SAT_EN
                    if (m_bins[ch][m_pend_bin[ch]] == MAXV) m_ovf[ch] = 1'b1;
                    else m_bins[ch][m_pend_bin[ch]] = m_bins[ch][m_pend_bin[ch]] + 1;
`else
                    m_bins[ch][m_pend_bin[ch]] = (m_bins[ch][m_pend_bin[ch]] + 1) % (MAXV + 1);
`endif
                end
            end
            m_pend = pixel_valid && !m_busy && !clear;
            for (int ch = 0; ch < NCH; ch++) m_pend_bin[ch] = int'(pixel_in[ch*PW +: PW]) >> (PW - AW);
            if (clear) begin
                if (!m_busy) m_ovf = '0;
                m_busy = 1'b1;
                m_left = CR;
            end else if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    for (int ch = 0; ch < NCH; ch++)
                        for (int b = 0; b < CR; b++) m_bins[ch][b] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_busy));
        chk("rd_valid", int'(rd_valid), int'(e_rd_valid));
        if (e_rd_valid) chk("rd_data", int'(rd_data), e_rd_data);
        chk("ovf", int'(ovf), int'(m_ovf));
    end

    task automatic drive(input bit pv, input logic [NCH*PW-1:0] pix, input bit clr,
                         input bit rq, input int rch, input int raddr);
        pixel_valid = pv;
        pixel_in    = pix;
        clear       = clr;
        rd_req      = rq;
        rd_ch       = rch[CW-1:0];
        rd_addr     = raddr[AW-1:0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic read_chk(input string name, input int ch, input int addr, input int exp);
        drive(1'b0, '0, 1'b0, 1'b1, ch, addr);
        chk({name, "_valid"}, int'(rd_valid), 1);
        chk(name, int'(rd_data), exp);
        chk({name, "_model"}, e_rd_data, exp);
    endtask

    task automatic read_all_zero(input string name);
        for (int ch = 0; ch < NCH; ch++)
            for (int b = 0; b < CR; b++) read_chk(name, ch, b, 0);
        idle(1);
    endtask

    task automatic count_busy(output int n, input int clr_at, input bit pv);
        n = 0;
        while (busy && n < 500) begin
            n++;
            drive(pv, 24'h080808, (n == clr_at), 1'b0, 0, 0);
        end
    endtask

    int n;

    initial begin
        arstn = 1'b0;
        pixel_valid = 1'b0; pixel_in = '0; clear = 1'b0;
        rd_req = 1'b0; rd_ch = '0; rd_addr = '0;
        @(negedge clk);
        idle(2);
        chk("rst_busy", int'(busy), 1);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_ovf", int'(ovf), 0);
        arstn = 1'b1;

        count_busy(n, 0, 1'b0);
        chk("sweep_len", n, 64);
        read_all_zero("init_zero");

        // ch0 bin 5, ch1 bin 63 (0xFF), ch2 bin 0, ten back-to-back beats
        repeat (10) drive(1'b1, 24'h00FF14, 1'b0, 1'b0, 0, 0);
        idle(1);
        read_chk("b2b_ch0_bin5", 0, 5, 10);
        read_chk("b2b_ch1_bin63", 1, 63, 10);
        read_chk("b2b_ch2_bin0", 2, 0, 10);

        for (int i = 0; i < 8; i++) drive(1'b1, (i % 2 == 0) ? 24'h001414 : 24'h001818, 1'b0, 1'b0, 0, 0);
        repeat (2) drive(1'b1, 24'h001414, 1'b0, 1'b0, 0, 0);
        idle(1);
        read_chk("alt_ch1_bin5", 1, 5, 6);
        read_chk("alt_ch1_bin6", 1, 6, 4);
        read_chk("alt_ch0_bin5", 0, 5, 16);
        read_chk("alt_ch2_bin0", 2, 0, 20);

        // Push ch2 bin 0 from 20 to 35 beats: past the 5-bit maximum of 31
        repeat (15) drive(1'b1, 24'h008080, 1'b0, 1'b0, 0, 0);
        idle(1);
`ifdef HISTOGRAM_SAT_EN
        read_chk("sat_ch2_bin0", 2, 0, 31);
        chk("sat_ovf", int'(ovf), 4);
`else
        read_chk("wrap_ch2_bin0", 2, 0, 3);
        chk("wrap_ovf", int'(ovf), 0);
`endif
        read_chk("ch0_bin32", 0, 32, 15);
        read_chk("rd_ch3", 3, 5, 0);

        // Clear with a beat in stage 1, beats during busy, and a restart mid-sweep
        drive(1'b1, 24'h080808, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 24'h080808, 1'b1, 1'b0, 0, 0);
        count_busy(n, 11, 1'b1);
        chk("clear_sweep_len", n, 75);
        chk("clear_ovf", int'(ovf), 0);
        read_all_zero("clear_zero");

        drive(1'b1, 24'h1C1C1C, 1'b0, 1'b0, 0, 0);
        read_chk("collide_old", 0, 7, 0);
        read_chk("collide_new", 0, 7, 1);

        repeat (2) drive(1'b1, 24'h1C1C1C, 1'b0, 1'b0, 0, 0);
        #2 arstn = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_rd_valid", int'(rd_valid), 0);
        idle(1);
        arstn = 1'b1;
        count_busy(n, 0, 1'b0);
        chk("midrst_sweep_len", n, 64);
        read_chk("midrst_ch0_bin7", 0, 7, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/histogram_mc.md
# histogram_mc

Multi-channel, parametrised histogram accumulator for the pixel pipeline. It counts NUM_CH pixel components per beat into per-channel bin RAMs, using read-modify-write with same-bin forwarding so back-to-back identical pixels are never lost. It sweeps all RAMs to zero on reset release and on a clear request, and serves a one-cycle random-access readout port. It sits after the pixel source and ahead of histogram consumers (equaliser LUT builder, CPU readout).

## Interface
- PIXEL_WIDTH, 8, bits per channel component
- NUM_CH, 3, channel count; 1 is legal
- IMAGE_WIDTH, 640, pixels per line
- IMAGE_HEIGHT, 480, lines per frame
- COLOR_RANGE, 256, bins per channel; power of two, ≤ 2^PIXEL_WIDTH
- Derived: DATA_WIDTH = clogb2(IMAGE_WIDTH*IMAGE_HEIGHT), so a full single-bin frame fits. ADDRESS_WIDTH = clogb2(COLOR_RANGE-1). CH_WIDTH = max(1, clogb2(NUM_CH-1)).
- clk  in  1  sole clock, all logic on rising edge
- arstn  in  1  asynchronous, active-low reset
- pixel_in  in  NUM_CH*PIXEL_WIDTH  packed components, channel 0 in LSBs
- pixel_valid  in  1  beat qualifier
- clear  in  1  single-cycle request to zero all bins
- busy  out  1  clear sweep in progress
- rd_req  in  1  readout request
- rd_ch  in  CH_WIDTH  readout channel
- rd_addr  in  ADDRESS_WIDTH  readout bin
- rd_data  out  DATA_WIDTH  bin count
- rd_valid  out  1  rd_data qualifier
- ovf  out  NUM_CH  sticky per-channel saturation flag

## Operation
- Bin index = component >> (PIXEL_WIDTH-ADDRESS_WIDTH).
- FSM has two states, SWEEP and RUN. Reset enters SWEEP.
  - SWEEP: the address counter runs 0..COLOR_RANGE-1 and writes 0 to every channel's RAM each cycle. It goes to RUN after the last bin. ovf is cleared on entry.
  - RUN: accumulates pixels and serves reads. A clear in RUN goes to SWEEP with the counter at 0.
  - A clear in SWEEP restarts the counter at 0.
- Stage 0 (beat cycle t): issue the RAM read for each channel, and register the bin and valid.
- Stage 1 (t+1): old = bypass ? last_wr_data : ram_q.
  - bypass = the previous write was valid and its address equals this bin, per channel.
  - Write old+1 at end of t+1, and register it as last_wr_data/last_wr_addr.
  - A one-deep bypass is sufficient. Any beat at t+2 or later reads committed data.
- During SWEEP:
  - pixel_valid beats are dropped.
  - A stage-1 write already in flight when clear is sampled is suppressed.
  - rd_req is ignored.
- Readout is on port B of each RAM. Channel and address are registered, then muxed by the registered rd_ch. rd_ch ≥ NUM_CH returns 0 with rd_valid high.
- Simultaneous write and read of the same bin: the readout returns the pre-increment value.

## Timing
- Reset values: busy=1 (sweep starts on release), rd_valid=0, rd_data=0, ovf=0. RAM contents are undefined until the sweep ends.
- Sweep lasts exactly COLOR_RANGE cycles. busy falls in the cycle after the last zero write. pixel_valid is accepted from that cycle on.
- Increment latency: a beat at t is committed at end of t+1. It is visible to rd_req issued at t+2 or later.
- Readout latency: rd_req at t gives rd_valid/rd_data at t+1. There is one request per cycle and no back-pressure.
- arstn asserted mid-operation aborts everything and restarts the sweep.

## Configuration
- HISTOGRAM_SAT_EN defined:
  - Each increment saturates at 2^DATA_WIDTH-1.
  - An attempted increment past that value sets the channel's ovf bit, which stays set until the next sweep.
- HISTOGRAM_SAT_EN undefined:
  - Counts wrap modulo 2^DATA_WIDTH.
  - ovf is tied to 0.

## Structure
- hist_pkg holds the clogb2 function, the SWEEP/RUN state encoding, and the derived-width helper constants.
- One sub-module, hist_bin_ram: simple dual-port RAM, parameters DATA_WIDTH and ADDRESS_WIDTH.
  - Port A: synchronous read plus write, read-old on collision.
  - Port B: synchronous read only.
  - Instantiated NUM_CH times with generate.

## Test plan
- Reset release -> busy=1 for exactly 256 cycles, then 0. Reading every bin of every channel then returns 0.
- 10 consecutive beats of channel 0 = 0x05, then 1 idle cycle -> read ch0 bin 5 returns 10, with no lost increments (bypass).
- Alternating 0x05/0x06 for 8 beats, then 0x05, 0x05 -> bin 5 = 6, bin 6 = 4.
- Clear pulsed mid-stream with a beat in stage 1 -> that increment is not written, beats during busy are dropped, all bins read 0 afterwards.
- With COLOR_RANGE=64, input 0xFF -> bin 63 increments. rd_ch=3 with NUM_CH=3 -> rd_data=0, rd_valid=1.
- With HISTOGRAM_SAT_EN defined, DATA_WIDTH forced small, bin driven past max -> holds 2^DATA_WIDTH-1 and ovf bit set. Without the macro -> wraps to 0 and ovf stays 0.
